// File: rtl/tsc_control_sequencer.sv
// Multi-cycle fetch/execute sequencer for the TSC datapath: owns PC, IR and the retired-instruction count.
// Latency: at least 2 cycles per instruction (FETCH + EXEC); IDLE adds one cycle after reset.
// Backpressure: FETCH holds readM/address until inputReady is sampled high; HALT stalls until reset.
//
// Ports:
//   clk, reset_n             clock (rising edge) and asynchronous active-low reset
//   readM, address           memory read request and fetch address (PC), valid in FETCH only
//   data, inputReady         memory read data and its valid strobe, sampled in FETCH only
//   instruction              latched IR, used by the datapath for field parsing
//   RegDst, RegWrite, ALUSrc, ALUOp, Jump, isWWD
//                            datapath controls, nonzero only in EXEC
//   num_inst                 retired-instruction count
//   halted, illegal          HLT reached / undefined instruction retired as NOP (one-cycle pulse)
module tsc_control_sequencer #(
   parameter int                   WORD_SIZE = 16,
   parameter logic [WORD_SIZE-1:0] PC_RESET  = '0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   output logic                 readM,
   output logic [WORD_SIZE-1:0] address,
   input  logic [WORD_SIZE-1:0] data,
   input  logic                 inputReady,
   output logic [WORD_SIZE-1:0] instruction,
   output logic                 RegDst,
   output logic                 RegWrite,
   output logic                 ALUSrc,
   output logic [3:0]           ALUOp,
   output logic                 Jump,
   output logic                 isWWD,
   output logic [WORD_SIZE-1:0] num_inst,
   output logic                 halted,
   output logic                 illegal
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_HALT
   } state_e;

   localparam logic [3:0] OP_ADI = 4'd4;
   localparam logic [3:0] OP_ORI = 4'd5;
   localparam logic [3:0] OP_LHI = 4'd6;
   localparam logic [3:0] OP_JMP = 4'd9;
   localparam logic [3:0] OP_R   = 4'd15;
   localparam logic [5:0] FN_WWD = 6'd28;
   localparam logic [5:0] FN_HLT = 6'd29;

   state_e               state_q, state_d;
   logic [WORD_SIZE-1:0] pc_q, pc_d;
   logic [WORD_SIZE-1:0] ir_q, ir_d;
   logic [WORD_SIZE-1:0] num_q, num_d;

   logic [3:0] opcode;
   logic [5:0] func;

   assign opcode      = ir_q[15:12];
   assign func        = ir_q[5:0];
   assign instruction = ir_q;
   assign num_inst    = num_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         pc_q    <= PC_RESET;
         ir_q    <= '0;
         num_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         num_q   <= num_d;
      end
   end

   // All controls are decoded from the registered state and IR, so an
   // asynchronous reset forces them low immediately (no RF write can complete).
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      num_d    = num_q;
      readM    = 1'b0;
      address  = '0;
      RegDst   = 1'b0;
      RegWrite = 1'b0;
      ALUSrc   = 1'b0;
      ALUOp    = 4'd0;
      Jump     = 1'b0;
      isWWD    = 1'b0;
      halted   = 1'b0;
      illegal  = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end

         S_FETCH: begin
            readM   = 1'b1;
            address = pc_q;
            if (inputReady) begin
               ir_d    = data;
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            num_d   = num_q + WORD_SIZE'(1);
            pc_d    = pc_q + WORD_SIZE'(1);
            state_d = S_FETCH;
            case (opcode)
               OP_ADI: begin
                  RegWrite = 1'b1;
                  ALUSrc   = 1'b1;
                  ALUOp    = 4'd0;
               end
               OP_ORI: begin
                  RegWrite = 1'b1;
                  ALUSrc   = 1'b1;
                  ALUOp    = 4'd3;
               end
               OP_LHI: begin
                  RegWrite = 1'b1;
                  ALUSrc   = 1'b1;
                  ALUOp    = 4'd8;
               end
               OP_JMP: begin
                  Jump = 1'b1;
                  // Jump stays within the current 4K page.
                  pc_d = {pc_q[WORD_SIZE-1:12], ir_q[11:0]};
               end
               OP_R: begin
                  if (func < 6'd8) begin
                     RegWrite = 1'b1;
                     RegDst   = 1'b1;
                     ALUOp    = func[3:0];
                  end else if (func == FN_WWD) begin
                     isWWD = 1'b1;
                  end else if (func == FN_HLT) begin
                     state_d = S_HALT;
                  end else begin
                     illegal = 1'b1;
                  end
               end
               default: begin
                  illegal = 1'b1;
               end
            endcase
         end

         S_HALT: begin
            halted = 1'b1;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_tsc_control_sequencer.sv
// Self-checking bench for tsc_control_sequencer: directed table, randomized
// instruction stream against a reference model, and reset/halt corner cases.
module tb_tsc_control_sequencer;

   localparam logic [15:0] PCR = 16'hFFF8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        readM;
   logic [15:0] address;
   logic [15:0] data;
   logic        inputReady;
   logic [15:0] instruction;
   logic        RegDst, RegWrite, ALUSrc, Jump, isWWD, halted, illegal;
   logic [3:0]  ALUOp;
   logic [15:0] num_inst;

   always #5 clk = ~clk;

   tsc_control_sequencer #(.WORD_SIZE(16), .PC_RESET(PCR)) dut (
      .clk(clk), .reset_n(reset_n), .readM(readM), .address(address),
      .data(data), .inputReady(inputReady), .instruction(instruction),
      .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
      .Jump(Jump), .isWWD(isWWD), .num_inst(num_inst), .halted(halted),
      .illegal(illegal)
   );

   // {RegDst, RegWrite, ALUSrc, ALUOp[3:0], Jump, isWWD, illegal, halted}
   logic [10:0] ctrl_act;
   assign ctrl_act = {RegDst, RegWrite, ALUSrc, ALUOp, Jump, isWWD, illegal, halted};

   localparam logic [10:0] C_ADI  = 11'b011_0000_0000;
   localparam logic [10:0] C_ORI  = 11'b011_0011_0000;
   localparam logic [10:0] C_LHI  = 11'b011_1000_0000;
   localparam logic [10:0] C_JMP  = 11'b000_0000_1000;
   localparam logic [10:0] C_WWD  = 11'b000_0000_0100;
   localparam logic [10:0] C_ILL  = 11'b000_0000_0010;
   localparam logic [10:0] C_HALT = 11'b000_0000_0001;

   typedef struct {
      logic [15:0] ins;
      int          wt;
      logic [10:0] exp;
   } vec_t;

   vec_t tbl[17];

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] m_pc, m_num, m_ir;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected EXEC-cycle controls straight from the instruction-set table.
   function automatic logic [10:0] ref_ctrl(input logic [15:0] ins);
      logic [3:0] op;
      logic [5:0] fn;
      op = ins[15:12];
      fn = ins[5:0];
      if (op == 4'd4)       return C_ADI;
      else if (op == 4'd5)  return C_ORI;
      else if (op == 4'd6)  return C_LHI;
      else if (op == 4'd9)  return C_JMP;
      else if (op == 4'd15) begin
         if (fn <= 6'd7)       return {3'b110, fn[3:0], 4'b0000};
         else if (fn == 6'd28) return C_WWD;
         else if (fn == 6'd29) return 11'd0;
         else                  return C_ILL;
      end
      return C_ILL;
   endfunction

   // Entered at a falling edge; returns at the falling edge after EXEC closes.
   task automatic exec_inst(input logic [15:0] ins, input int wt, input logic [10:0] exp);
      int  k;
      logic hlt;
      k = 0;
      inputReady = 1'b0;
      while (!readM && k < 4) begin
         @(negedge clk);
         k++;
      end
      chk("fetch_req", readM, 1);
      chk("fetch_addr", address, m_pc);
      for (int i = 0; i < wt; i++) begin
         inputReady = 1'b0;
         data       = 16'($urandom);
         chk("wait_readM", readM, 1);
         chk("wait_addr", address, m_pc);
         chk("wait_ctrl", ctrl_act, 0);
         chk("wait_ir", instruction, m_ir);
         @(negedge clk);
      end
      inputReady = 1'b1;
      data       = ins;
      @(negedge clk);
      // Junk on the memory interface during EXEC must be ignored.
      inputReady = 1'($urandom_range(0, 1));
      data       = 16'($urandom);
      chk("exec_ctrl", ctrl_act, exp);
      chk("exec_ir", instruction, ins);
      chk("exec_readM", readM, 0);
      chk("exec_num", num_inst, m_num);
      m_ir  = ins;
      m_num = m_num + 16'd1;
      m_pc  = (ins[15:12] == 4'd9) ? {m_pc[15:12], ins[11:0]} : m_pc + 16'd1;
      hlt   = (ins[15:12] == 4'd15) && (ins[5:0] == 6'd29);
      @(negedge clk);
      inputReady = 1'b0;
      chk("post_ctrl", ctrl_act, hlt ? C_HALT : 11'd0);
      chk("post_num", num_inst, m_num);
      chk("post_ir", instruction, m_ir);
   endtask

   initial begin
      logic [15:0] ins;
      int          k;

      tbl[0]  = '{16'h4105, 0, C_ADI};
      tbl[1]  = '{16'h5234, 3, C_ORI};
      tbl[2]  = '{16'h6345, 1, C_LHI};
      tbl[3]  = '{16'hF01C, 0, C_WWD};
      tbl[4]  = '{16'hE000, 2, C_ILL};
      tbl[5]  = '{16'hF0C1, 0, 11'b110_0001_0000};
      tbl[6]  = '{16'hF0C2, 1, 11'b110_0010_0000};
      tbl[7]  = '{16'hF0C0, 0, 11'b110_0000_0000};
      tbl[8]  = '{16'hF0C3, 0, 11'b110_0011_0000};
      tbl[9]  = '{16'hF0C4, 2, 11'b110_0100_0000};
      tbl[10] = '{16'hF0C5, 0, 11'b110_0101_0000};
      tbl[11] = '{16'hF0C6, 0, 11'b110_0110_0000};
      tbl[12] = '{16'hF0C7, 1, 11'b110_0111_0000};
      tbl[13] = '{16'hF01E, 0, C_ILL};
      tbl[14] = '{16'hF008, 0, C_ILL};
      tbl[15] = '{16'h0000, 0, C_ILL};
      tbl[16] = '{16'h9ABC, 0, C_JMP};

      reset_n    = 1'b0;
      inputReady = 1'b1;
      data       = 16'hA5A5;
      m_pc       = PCR;
      m_num      = 16'd0;
      m_ir       = 16'd0;

      #3;
      chk("rst_readM", readM, 0);
      chk("rst_addr", address, 0);
      chk("rst_ir", instruction, 0);
      chk("rst_ctrl", ctrl_act, 0);
      chk("rst_num", num_inst, 0);
      @(negedge clk);
      inputReady = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      // Directed table; entry 7 (ADD) sits at PC 0xFFFF.
      for (int i = 0; i < 17; i++) begin
         exec_inst(tbl[i].ins, tbl[i].wt, tbl[i].exp);
         if (i == 7) chk("wrap_addr", address, 16'h0000);
      end
      chk("tbl_jmp_addr", address, 16'h0ABC);

      // Randomized stream biased toward defined instructions (HLT excluded).
      for (int n = 0; n < 300; n++) begin
         ins = 16'($urandom);
         case ($urandom_range(0, 7))
            0: ins[15:12] = 4'd4;
            1: ins[15:12] = 4'd5;
            2: ins[15:12] = 4'd6;
            3: ins[15:12] = 4'd9;
            4, 5: begin
               ins[15:12] = 4'd15;
               ins[5:0]   = 6'($urandom_range(0, 7));
            end
            6: begin
               ins[15:12] = 4'd15;
               ins[5:0]   = 6'd28;
            end
            default: ;
         endcase
         if (ins[15:12] == 4'd15 && ins[5:0] == 6'd29) ins[0] = 1'b0;
         exec_inst(ins, $urandom_range(0, 2), ref_ctrl(ins));
      end

      // Walk the PC up to 0x5007 with zero-wait ADIs.
      k = 0;
      while (m_pc != 16'h5007 && k < 30000) begin
         exec_inst(16'h4105, 0, C_ADI);
         k++;
      end
      chk("ff_reach", address, 16'h5007);

      exec_inst(16'h9123, 0, C_JMP);
      chk("jmp_target", address, 16'h5123);
      exec_inst(16'h4105, 0, C_ADI);

      // Reset asserted in the EXEC cycle of an ADD.
      k = 0;
      while (!readM && k < 4) begin
         @(negedge clk);
         k++;
      end
      inputReady = 1'b1;
      data       = 16'hF0C0;
      @(negedge clk);
      inputReady = 1'b0;
      chk("rst_exec_rw", RegWrite, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_rw", RegWrite, 0);
      chk("rst_async_ctrl", ctrl_act, 0);
      chk("rst_async_num", num_inst, 0);
      chk("rst_async_ir", instruction, 0);
      @(negedge clk);
      reset_n = 1'b1;
      m_pc  = PCR;
      m_num = 16'd0;
      m_ir  = 16'd0;
      exec_inst(16'h4105, 0, C_ADI);
      chk("after_rst_num", num_inst, 1);

      // HLT: EXEC cycle shows no controls, then permanent halt.
      exec_inst(16'hF01D, 1, 11'd0);
      for (int c = 0; c < 20; c++) begin
         inputReady = 1'b1;
         data       = 16'h4105;
         chk("halt_readM", readM, 0);
         chk("halt_ctrl", ctrl_act, C_HALT);
         chk("halt_num", num_inst, m_num);
         @(negedge clk);
      end
      inputReady = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
